// File: rtl/controller_pkg.sv
// controller_pkg: shared types and constants for the controller GPIO blocks.
//   state_t       - feedback sequencer states (IDLE, ARMED, WIN, SHOW)
//   NUM_PLAYERS   - number of player stations on the header
//   player_id_t   - 2-bit player index, same encoding as the input block
//                   select (00 = P1 .. 11 = P4)
//   player_onehot - turns a player index into a one-hot pin vector
package controller_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef logic [1:0] player_id_t;

    localparam player_id_t P1 = 2'd0;
    localparam player_id_t P2 = 2'd1;
    localparam player_id_t P3 = 2'd2;
    localparam player_id_t P4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WIN   = 2'd2,
        SHOW  = 2'd3
    } state_t;

    function automatic logic [NUM_PLAYERS-1:0] player_onehot(input player_id_t id);
        player_onehot     = '0;
        player_onehot[id] = 1'b1;
    endfunction

endpackage

// File: rtl/controller_feedback_blink_timer.sv
// blink_timer: free-running cycle counter that produces a one-cycle tick
// every CYCLES enabled cycles.
//   clk   - system clock
//   reset - asynchronous active-high reset (counter to 0)
//   clr   - synchronous clear to 0, wins over en
//   en    - count enable; the counter holds when low
//   tick  - high in the enabled cycle where the counter sits at CYCLES-1;
//           the counter wraps to 0 on the following edge
module blink_timer #(
    parameter int CYCLES = 12500000,
    parameter int CNT_W  = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controller_feedback.sv
// controller_feedback: drives the player-facing LEDs and buzzers of the
// controller GPIO header from game-side events.
//   clk, reset     - clock, asynchronous active-high reset
//   clear          - synchronous abort to IDLE, beats every other input
//   arm            - opens the buzz window (IDLE -> ARMED)
//   winnerValid/winnerId     - first buzzer, id latched in ARMED only
//   resultValid/resultCorrect - judged answer, latched in WIN only
//   playerLeds, playerBuzzer - pin drive, bit n = player n+1
//   busy           - high whenever the sequencer is not in IDLE
//   done           - one-cycle pulse when a result display runs to its end
//   dbg_state      - current sequencer state, for observation only
// Build option: FEEDBACK_ATTRACT_EN adds a one-hot LED chase while idle.
//
// Event inputs are single-cycle valid strobes with no ready: the block can
// always accept, and an event is either acted on in the cycle it is seen or
// dropped if the current state does not expect it.
module controller_feedback
    import controller_pkg::*;
#(
    parameter int BLINK_CYCLES = 12500000,
    parameter int BLINK_COUNT  = 6,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       arm,
    input  logic       winnerValid,
    input  logic [1:0] winnerId,
    input  logic       resultValid,
    input  logic       resultCorrect,
    output logic [3:0] playerLeds,
    output logic [3:0] playerBuzzer,
    output logic       busy,
    output logic       done,
    output state_t     dbg_state
);

    localparam int HALF_W = (BLINK_COUNT < 2) ? 1 : $clog2(BLINK_COUNT);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(BLINK_COUNT - 1);

    state_t            state, state_n;
    player_id_t        id_q, id_n;
    logic              correct_q, correct_n;
    logic [HALF_W-1:0] half_q, half_n;
    logic              phase_q, phase_n;     // blink phase, 1 = LED lit
    logic [3:0]        leds_n, buz_n;
    logic              busy_n, done_n;
    logic              tmr_clr, tmr_en, tick;

`ifdef FEEDBACK_ATTRACT_EN
    localparam logic [3:0] CHASE_START = 4'b0001;
    logic [3:0] chase_q, chase_n;
`endif

    assign dbg_state = state;

    blink_timer #(
        .CYCLES (BLINK_CYCLES),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tick  (tick)
    );

    always_comb begin
        state_n   = state;
        id_n      = id_q;
        correct_n = correct_q;
        half_n    = half_q;
        phase_n   = phase_q;
        done_n    = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
`ifdef FEEDBACK_ATTRACT_EN
        chase_n   = chase_q;
`endif
        if (clear) begin
            state_n = IDLE;
            tmr_clr = 1'b1;
            half_n  = '0;
            phase_n = 1'b0;
`ifdef FEEDBACK_ATTRACT_EN
            chase_n = CHASE_START;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef FEEDBACK_ATTRACT_EN
                    tmr_en = 1'b1;
                    if (!arm && tick) chase_n = {chase_q[2:0], chase_q[3]};
`else
                    tmr_clr = 1'b1;
`endif
                    // winnerValid/resultValid are deliberately not looked at here
                    if (arm) begin
                        state_n = ARMED;
                        tmr_clr = 1'b1;
                    end
                end
                ARMED: begin
                    // A result arriving with the winner is dropped: WIN must see its own.
                    if (winnerValid) begin
                        state_n = WIN;
                        id_n    = winnerId;
                    end
                end
                WIN: begin
                    if (resultValid) begin
                        state_n   = SHOW;
                        correct_n = resultCorrect;
                        half_n    = '0;
                        phase_n   = 1'b1;
                        tmr_clr   = 1'b1;
                    end
                end
                SHOW: begin
                    tmr_en = 1'b1;
                    if (tick) begin
                        if (half_q == LAST_HALF) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            half_n  = '0;
                            phase_n = 1'b0;
                            tmr_clr = 1'b1;
`ifdef FEEDBACK_ATTRACT_EN
                            chase_n = CHASE_START;
`endif
                        end else begin
                            half_n  = half_q + 1'b1;
                            phase_n = ~phase_q;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Pin values follow the state being entered so they land one edge
        // after the event that caused the transition.
        leds_n = '0;
        buz_n  = '0;
        case (state_n)
            IDLE: begin
`ifdef FEEDBACK_ATTRACT_EN
                leds_n = chase_n;
`endif
            end
            ARMED: leds_n = '1;
            WIN:   leds_n = player_onehot(id_n);
            SHOW: begin
                if (correct_n) begin
                    leds_n = phase_n ? player_onehot(id_n) : '0;
                end else begin
                    leds_n = player_onehot(id_n);
                    buz_n  = player_onehot(id_n);
                end
            end
            default: leds_n = '0;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            id_q         <= P1;
            correct_q    <= 1'b0;
            half_q       <= '0;
            phase_q      <= 1'b0;
            playerLeds   <= '0;
            playerBuzzer <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            id_q         <= id_n;
            correct_q    <= correct_n;
            half_q       <= half_n;
            phase_q      <= phase_n;
            playerLeds   <= leds_n;
            playerBuzzer <= buz_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

`ifdef FEEDBACK_ATTRACT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chase_q <= CHASE_START;
        else       chase_q <= chase_n;
    end
`endif

endmodule

// File: tb/tb_controller_feedback.sv
module tb_controller_feedback;
  import controller_pkg::*;

  localparam int BCY = 4;
  localparam int BN  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       clear = 1'b0;
  logic       arm = 1'b0;
  logic       winnerValid = 1'b0;
  logic [1:0] winnerId = 2'd0;
  logic       resultValid = 1'b0;
  logic       resultCorrect = 1'b0;
  logic [3:0] playerLeds, playerBuzzer;
  logic       busy, done;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  controller_feedback #(
    .BLINK_CYCLES (BCY),
    .BLINK_COUNT  (BN),
    .CNT_W        (4)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .clear         (clear),
    .arm           (arm),
    .winnerValid   (winnerValid),
    .winnerId      (winnerId),
    .resultValid   (resultValid),
    .resultCorrect (resultCorrect),
    .playerLeds    (playerLeds),
    .playerBuzzer  (playerBuzzer),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Tracks mode and elapsed cycles; the display pattern is derived from the
  // number of cycles since SHOW / IDLE entry.
  state_t     m_mode;
  logic [1:0] m_id;
  logic       m_corr;
  int         m_el;
  int         m_idle_el;
  logic [3:0] exp_leds, exp_buz;
  logic       exp_busy, exp_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode    <= IDLE;
      m_id      <= 2'd0;
      m_corr    <= 1'b0;
      m_el      <= 0;
      m_idle_el <= 0;
      exp_leds  <= 4'b0;
      exp_buz   <= 4'b0;
      exp_busy  <= 1'b0;
      exp_done  <= 1'b0;
    end else begin : model_step
      state_t     md;
      int         el, iel;
      logic [1:0] id;
      logic       c, dn;
      logic [3:0] oh, lv, bv;
      md = m_mode; el = m_el; iel = m_idle_el + 1; id = m_id; c = m_corr; dn = 1'b0;
      if (clear) begin
        md = IDLE; iel = 0;
      end else begin
        case (m_mode)
          IDLE:  if (arm) md = ARMED;
          ARMED: if (winnerValid) begin md = WIN; id = winnerId; end
          WIN:   if (resultValid) begin md = SHOW; c = resultCorrect; el = 0; end
          SHOW: begin
            el = el + 1;
            if (el == BN * BCY) begin md = IDLE; dn = 1'b1; iel = 0; end
          end
          default: md = IDLE;
        endcase
      end
      oh = 4'b0001 << id;
      lv = 4'b0; bv = 4'b0;
      case (md)
        IDLE: begin
`ifdef FEEDBACK_ATTRACT_EN
          lv = 4'b0001 << ((iel / BCY) % 4);
`endif
        end
        ARMED: lv = 4'b1111;
        WIN:   lv = oh;
        SHOW: begin
          if (c) lv = (((el / BCY) % 2) == 0) ? oh : 4'b0;
          else begin lv = oh; bv = oh; end
        end
        default: lv = 4'b0;
      endcase
      m_mode    <= md;
      m_id      <= id;
      m_corr    <= c;
      m_el      <= el;
      m_idle_el <= iel;
      exp_leds  <= lv;
      exp_buz   <= bv;
      exp_busy  <= (md != IDLE);
      exp_done  <= dn;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    chk("leds",   playerLeds,        exp_leds);
    chk("buzzer", playerBuzzer,      exp_buz);
    chk("busy",   {3'b0, busy},      {3'b0, exp_busy});
    chk("done",   {3'b0, done},      {3'b0, exp_done});
    chk("state",  {2'b0, dbg_state}, {2'b0, m_mode});
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [3:0] chase_seq [4];
    chase_seq[0] = 4'b0010; chase_seq[1] = 4'b0100;
    chase_seq[2] = 4'b1000; chase_seq[3] = 4'b0001;

    step(); step();
    rst = 1'b0;
    chk("rst_leds",  playerLeds,        4'b0000);
    chk("rst_busy",  {3'b0, busy},      4'b0000);
    chk("rst_done",  {3'b0, done},      4'b0000);
    chk("rst_state", {2'b0, dbg_state}, {2'b0, IDLE});

    // winnerValid alone in IDLE does nothing
    winnerValid = 1'b1; winnerId = 2'd1; step(); winnerValid = 1'b0;
    chk("idle_win_busy",  {3'b0, busy},      4'b0000);
    chk("idle_win_state", {2'b0, dbg_state}, {2'b0, IDLE});

    // arm, then winner 2
    arm = 1'b1; step(); arm = 1'b0;
    chk("armed_leds", playerLeds,   4'b1111);
    chk("armed_busy", {3'b0, busy}, 4'b0001);
    winnerId = 2'd2; winnerValid = 1'b1; step(); winnerValid = 1'b0; winnerId = 2'd3;
    chk("win_leds", playerLeds, 4'b0100);
    arm = 1'b1; step(); arm = 1'b0;
    chk("win_arm_ignored", playerLeds, 4'b0100);

    // correct result: blink on/off/on/off
    resultValid = 1'b1; resultCorrect = 1'b1; step(); resultValid = 1'b0;
    chk("show_c_entry", playerLeds, 4'b0100);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 4)  chk("show_c_off1", playerLeds, 4'b0000);
      if (k == 8)  chk("show_c_on2",  playerLeds, 4'b0100);
      if (k == 12) chk("show_c_off2", playerLeds, 4'b0000);
      if (k == 15) chk("show_c_nodone", {3'b0, done}, 4'b0000);
      if (k == 16) begin
        chk("show_c_done", {3'b0, done}, 4'b0001);
        chk("show_c_busy", {3'b0, busy}, 4'b0000);
        chk("show_c_led2", {3'b0, playerLeds[2]}, 4'b0000);
      end
    end
    step();
    chk("done_one_cycle", {3'b0, done}, 4'b0000);

    // incorrect result for player 1 (id 0)
    arm = 1'b1; step(); arm = 1'b0;
    winnerId = 2'd0; winnerValid = 1'b1; step(); winnerValid = 1'b0;
    resultValid = 1'b1; resultCorrect = 1'b0; step(); resultValid = 1'b0;
    chk("show_i_leds", playerLeds,   4'b0001);
    chk("show_i_buz",  playerBuzzer, 4'b0001);
    repeat (15) step();
    chk("show_i_leds15", playerLeds,   4'b0001);
    chk("show_i_buz15",  playerBuzzer, 4'b0001);
    step();
    chk("show_i_buz_end", playerBuzzer,  4'b0000);
    chk("show_i_done",    {3'b0, done}, 4'b0001);
    step();

    // winner and result together in ARMED: result dropped
    arm = 1'b1; step(); arm = 1'b0;
    winnerId = 2'd3; winnerValid = 1'b1; resultValid = 1'b1; resultCorrect = 1'b1;
    step(); winnerValid = 1'b0; resultValid = 1'b0;
    chk("simul_leds",  playerLeds,        4'b1000);
    chk("simul_state", {2'b0, dbg_state}, {2'b0, WIN});
    repeat (3) step();
    chk("simul_still_win", {2'b0, dbg_state}, {2'b0, WIN});
    resultValid = 1'b1; step(); resultValid = 1'b0;
    chk("simul_show", {2'b0, dbg_state}, {2'b0, SHOW});

    // clear in SHOW cycle 5, together with arm
    repeat (5) step();
    clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
    chk("clear_busy",  {3'b0, busy},      4'b0000);
    chk("clear_done",  {3'b0, done},      4'b0000);
    chk("clear_state", {2'b0, dbg_state}, {2'b0, IDLE});
    step();
    chk("clear_no_done", {3'b0, done}, 4'b0000);
    arm = 1'b1; step(); arm = 1'b0;
    chk("rearm_leds", playerLeds, 4'b1111);

    // asynchronous reset mid-display
    winnerId = 2'd1; winnerValid = 1'b1; step(); winnerValid = 1'b0;
    resultValid = 1'b1; resultCorrect = 1'b0; step(); resultValid = 1'b0;
    repeat (3) step();
    chk("pre_rst_buz", playerBuzzer, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", playerLeds,    4'b0000);
    chk("async_rst_buz",  playerBuzzer,  4'b0000);
    chk("async_rst_busy", {3'b0, busy},  4'b0000);
    step(); step();
    rst = 1'b0;
    chk("post_rst_state", {2'b0, dbg_state}, {2'b0, IDLE});

`ifdef FEEDBACK_ATTRACT_EN
    clear = 1'b1; step(); clear = 1'b0;
    chk("chase_0", playerLeds, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      repeat (BCY) step();
      chk("chase_step", playerLeds, chase_seq[i]);
    end
    chk("chase_busy", {3'b0, busy}, 4'b0000);
    arm = 1'b1; step(); arm = 1'b0;
    chk("chase_arm", playerLeds, 4'b1111);
    clear = 1'b1; step(); clear = 1'b0;
`endif

    // random pulse traffic, checked by the scoreboard each cycle
    for (int i = 0; i < 400; i++) begin
      arm           = ($urandom_range(0, 7) == 0);
      winnerValid   = ($urandom_range(0, 5) == 0);
      winnerId      = 2'($urandom_range(0, 3));
      resultValid   = ($urandom_range(0, 5) == 0);
      resultCorrect = 1'($urandom_range(0, 1));
      clear         = ($urandom_range(0, 60) == 0);
      step();
    end
    arm = 1'b0; winnerValid = 1'b0; resultValid = 1'b0; clear = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
